dma_wdata_beat_gen: RTL

Downstream companion of the DMA write-address burst generator. It accepts one burst descriptor (AXI length plus write strobe) per issued AW burst and queues it. It then drives the AXI W channel from a streaming data source, asserting WLAST on the final beat of each burst. It also retires B responses, pulsing done when the final burst of a transfer is acknowledged and flagging any non-OKAY response.

---
 rtl/dma_wdata_beat_gen_pkg.sv | 17 +
 rtl/dma_wdata_beat_gen_if.sv | 35 +++
 rtl/dma_wdata_beat_gen_desc_fifo.sv | 65 ++++++
 rtl/dma_wdata_beat_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dma_wdata_beat_gen_pkg.sv
// Shared constants and types for the DMA write-data beat generator.
// Holds the B-response encoding, the FSM states and the descriptor record width.
package dma_wdata_beat_gen_pkg;

   localparam logic [1:0] AXI_BRESP_OKAY = 2'b00;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BEAT = 1'b1
   } beat_state_t;

   // Packed descriptor layout is {len, wstrb, last}.
   function automatic int desc_width(input int bw_alen, input int bw_data);
      return bw_alen + bw_data / 8 + 1;
   endfunction

endpackage

// File: rtl/dma_wdata_beat_gen_if.sv
// Descriptor, stream-in, AXI W and AXI B channels of the beat generator.
// The master side is the environment; the slave side is the beat generator.
interface dma_wdata_beat_gen_if #(
   parameter int BW_AXI_DATA = 32,
   parameter int BW_AXI_ALEN = 8
);
   logic                     desc_valid;
   logic                     desc_ready;
   logic [BW_AXI_ALEN-1:0]   desc_len;
   logic [BW_AXI_DATA/8-1:0] desc_wstrb;
   logic                     desc_last;
   logic                     din_valid;
   logic                     din_ready;
   logic [BW_AXI_DATA-1:0]   din_data;
   logic                     wvalid;
   logic                     wready;
   logic [BW_AXI_DATA-1:0]   wdata;
   logic [BW_AXI_DATA/8-1:0] wstrb;
   logic                     wlast;
   logic                     bvalid;
   logic                     bready;
   logic [1:0]               bresp;

   modport master (
      output desc_valid, desc_len, desc_wstrb, desc_last,
      output din_valid, din_data, wready, bvalid, bresp,
      input  desc_ready, din_ready, wvalid, wdata, wstrb, wlast, bready
   );

   modport slave (
      input  desc_valid, desc_len, desc_wstrb, desc_last,
      input  din_valid, din_data, wready, bvalid, bresp,
      output desc_ready, din_ready, wvalid, wdata, wstrb, wlast, bready
   );
endinterface

// File: rtl/dma_wdata_beat_gen_desc_fifo.sv
// Synchronous descriptor FIFO with occupancy count; flushed by clear.
module dma_desc_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 4,
   localparam int BW_PTR = $clog2(DEPTH),
   localparam int BW_CNT = BW_PTR + 1
) (
   input  logic              clk,
   input  logic              rstnn,
   input  logic              clear,
   input  logic              push,
   input  logic [WIDTH-1:0]  din,
   input  logic              pop,
   output logic [WIDTH-1:0]  dout,
   output logic              full,
   output logic              empty,
   output logic [BW_CNT-1:0] count
);
   localparam logic [BW_PTR-1:0] PTR_ONE  = BW_PTR'(1'b1);
   localparam logic [BW_CNT-1:0] CNT_ONE  = BW_CNT'(1'b1);
   localparam logic [BW_CNT-1:0] CNT_FULL = BW_CNT'(DEPTH);

   logic [WIDTH-1:0]  mem_r [DEPTH];
   logic [BW_PTR-1:0] wr_ptr_r;
   logic [BW_PTR-1:0] rd_ptr_r;
   logic [BW_CNT-1:0] count_r;
   logic              push_ok_s;
   logic              pop_ok_s;

   assign full      = (count_r == CNT_FULL);
   assign empty     = (count_r == {BW_CNT{1'b0}});
   assign count     = count_r;
   assign dout      = mem_r[rd_ptr_r];
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Storage, pointers and occupancy
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         wr_ptr_r <= {BW_PTR{1'b0}};
         rd_ptr_r <= {BW_PTR{1'b0}};
         count_r  <= {BW_CNT{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (clear) begin
         wr_ptr_r <= {BW_PTR{1'b0}};
         rd_ptr_r <= {BW_PTR{1'b0}};
         count_r  <= {BW_CNT{1'b0}};
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: rtl/dma_wdata_beat_gen.sv
// AXI W-channel beat generator: replays queued burst descriptors over a data
// stream, inserts WLAST, and retires B responses into done/error status.
module dma_wdata_beat_gen
   import dma_wdata_beat_gen_pkg::*;
#(
   parameter int BW_AXI_DATA    = 32,
   parameter int BW_AXI_ALEN    = 8,
   parameter int DESC_DEPTH     = 4,
   parameter int BW_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rstnn,
   input  logic                  clear,
   dma_wdata_beat_gen_if.slave   bus,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);
   localparam int BW_STRB = BW_AXI_DATA / 8;
   localparam int BW_DESC = desc_width(BW_AXI_ALEN, BW_AXI_DATA);
   localparam int BW_CNT  = $clog2(DESC_DEPTH) + 1;
   localparam int BW_SUM  = ((BW_OUTSTANDING > BW_CNT) ? BW_OUTSTANDING : BW_CNT) + 2;
   localparam logic [BW_OUTSTANDING-1:0] OUT_ONE  = BW_OUTSTANDING'(1'b1);
   localparam logic [BW_OUTSTANDING-1:0] OUT_ZERO = {BW_OUTSTANDING{1'b0}};
   localparam logic [BW_SUM-1:0]         OUT_MAX  = BW_SUM'((1 << BW_OUTSTANDING) - 1);
   localparam logic [BW_AXI_ALEN-1:0]    BEAT_ONE = BW_AXI_ALEN'(1'b1);

   beat_state_t               state_r, next_state_s;
   logic [BW_AXI_ALEN-1:0]    beat_cnt_r, cur_len_r;
   logic [BW_STRB-1:0]        cur_wstrb_r;
   logic                      cur_last_r;
   logic [BW_OUTSTANDING-1:0] outstanding_r;
   logic                      final_sent_r, done_r, error_r;

   logic                      fifo_push_s, fifo_full_s, fifo_empty_s, pop_s;
   logic [BW_DESC-1:0]        fifo_dout_s;
   logic [BW_CNT-1:0]         fifo_count_s;
   logic [BW_SUM-1:0]         inflight_s;
   logic                      wvalid_s, din_ready_s, wlast_s;
   logic                      w_hs_s, wlast_hs_s, b_hs_s, done_set_s;

   // Everything accepted but not yet acknowledged must fit the outstanding counter.
   assign inflight_s     = BW_SUM'(outstanding_r) + BW_SUM'(fifo_count_s)
                         + BW_SUM'(state_r == ST_BEAT);
   assign bus.desc_ready = ~fifo_full_s & (inflight_s < OUT_MAX);
   assign fifo_push_s    = bus.desc_valid & bus.desc_ready;

   dma_desc_fifo #(.WIDTH(BW_DESC), .DEPTH(DESC_DEPTH)) u_desc_fifo (
      .clk   (clk),
      .rstnn (rstnn),
      .clear (clear),
      .push  (fifo_push_s),
      .din   ({bus.desc_len, bus.desc_wstrb, bus.desc_last}),
      .pop   (pop_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   // Next-state, descriptor pop and W-channel handshake outputs
   always_comb begin
      next_state_s = state_r;
      pop_s        = 1'b0;
      wvalid_s     = 1'b0;
      din_ready_s  = 1'b0;
      wlast_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               pop_s        = 1'b1;
               next_state_s = ST_BEAT;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_BEAT: begin
            wvalid_s    = bus.din_valid;
            din_ready_s = bus.wready;
            wlast_s     = bus.din_valid & (beat_cnt_r == cur_len_r);
            if (wvalid_s & bus.wready & wlast_s) begin
               if (!fifo_empty_s) begin
                  pop_s        = 1'b1;
                  next_state_s = ST_BEAT;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end else begin
               next_state_s = ST_BEAT;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   assign w_hs_s     = wvalid_s & bus.wready;
   assign wlast_hs_s = w_hs_s & wlast_s;
   assign b_hs_s     = bus.bvalid & bus.bready;
   assign done_set_s = b_hs_s & (outstanding_r == OUT_ONE) & ~wlast_hs_s & final_sent_r;

   assign bus.wvalid    = wvalid_s;
   assign bus.din_ready = din_ready_s;
   assign bus.wlast     = wlast_s;
   assign bus.wdata     = bus.din_data;
   assign bus.wstrb     = cur_wstrb_r;
   assign bus.bready    = (outstanding_r != OUT_ZERO);
   assign busy          = (state_r == ST_BEAT) | ~fifo_empty_s | (outstanding_r != OUT_ZERO);
   assign done          = done_r;
   assign error         = error_r;

   // FSM state and the active burst's descriptor and beat counter
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state_r     <= ST_IDLE;
         beat_cnt_r  <= {BW_AXI_ALEN{1'b0}};
         cur_len_r   <= {BW_AXI_ALEN{1'b0}};
         cur_wstrb_r <= {BW_STRB{1'b0}};
         cur_last_r  <= 1'b0;
      end else if (clear) begin
         state_r    <= ST_IDLE;
         beat_cnt_r <= {BW_AXI_ALEN{1'b0}};
      end else begin
         state_r <= next_state_s;
         if (pop_s) begin
            cur_len_r   <= fifo_dout_s[BW_DESC-1 -: BW_AXI_ALEN];
            cur_wstrb_r <= fifo_dout_s[BW_STRB:1];
            cur_last_r  <= fifo_dout_s[0];
            beat_cnt_r  <= {BW_AXI_ALEN{1'b0}};
         end else if (w_hs_s) begin
            beat_cnt_r <= beat_cnt_r + BEAT_ONE;
         end
      end
   end

   // Bursts already issued on the bus keep being counted and drained across clear.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         outstanding_r <= OUT_ZERO;
      end else begin
         case ({wlast_hs_s, b_hs_s})
            2'b10:   outstanding_r <= outstanding_r + OUT_ONE;
            2'b01:   outstanding_r <= outstanding_r - OUT_ONE;
            default: outstanding_r <= outstanding_r;
         endcase
      end
   end

   // Completion and sticky error status
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         final_sent_r <= 1'b0;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
      end else if (clear) begin
         final_sent_r <= 1'b0;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         done_r <= done_set_s;
         if (done_set_s) begin
            final_sent_r <= 1'b0;
         end else if (wlast_hs_s & cur_last_r) begin
            final_sent_r <= 1'b1;
         end
         if (b_hs_s & (bus.bresp != AXI_BRESP_OKAY)) begin
            error_r <= 1'b1;
         end
      end
   end
endmodule
